div24_restoring: RTL and testbench

- Sequential radix-2 restoring divider for 24-bit IEEE754 mantissas; the inverse datapath of the mantissa multiplier in the FP divide path.
- Computes Q = floor({in1, WIDTH'b0} / in2), plus remainder and sticky bit for the downstream normaliser/rounder.
- Uses a start/done handshake and performs one quotient bit per clock.

---
 rtl/div24_pkg.sv | 19 +
 rtl/unit_div24_step.sv | 25 ++
 rtl/div24_restoring.sv | 145 ++++++++++++++
 tb/tb_div24_restoring.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/div24_pkg.sv
// Shared types and constants for the restoring mantissa divider.
package div24_pkg;

  localparam int unsigned WIDTH_DEFAULT = 24;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

  // Iteration counter width for a 2*width-bit quotient.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(2 * width);
  endfunction

  localparam int unsigned CNT_W_DEFAULT = $clog2(2 * WIDTH_DEFAULT);

endpackage

// File: rtl/unit_div24_step.sv
// One radix-2 restoring division step: shift in a dividend bit, try to subtract the divisor.
module unit_div24_step
  import div24_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // Trial subtraction; rem < divisor keeps trial < 2*divisor, so the MSB of diff is the borrow.
  always_comb begin
    trial    = {rem, next_bit};
    diff     = trial - {1'b0, divisor};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/div24_restoring.sv
// Sequential radix-2 restoring divider: Q = floor({in1, 0} / in2), one quotient bit per clock.
module div24_restoring
  import div24_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Q,
  output logic [WIDTH-1:0]   R,
  output logic               sticky,
  output logic               dbz
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(2 * WIDTH - 1);

  div_state_t state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [2*WIDTH-1:0] dividend_q, dividend_d;
  // Partial remainder stays below the divisor, so WIDTH bits hold it between steps.
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [2*WIDTH-1:0] quot_q, quot_d;
  logic               zero_div_q, zero_div_d;
  logic [2*WIDTH-1:0] q_out_q, q_out_d;
  logic [WIDTH-1:0]   r_out_q, r_out_d;
  logic               sticky_q, sticky_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   step_rem;
  logic               step_q;

  unit_div24_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem      (rem_q),
    .next_bit (dividend_q[2*WIDTH-1]),
    .divisor  (divisor_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // Next-state and datapath update; results are published only on entry to DONE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    divisor_d  = divisor_q;
    dividend_d = dividend_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    zero_div_d = zero_div_q;
    q_out_d    = q_out_q;
    r_out_d    = r_out_q;
    sticky_d   = sticky_q;
    dbz_d      = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          divisor_d  = in2;
          dividend_d = {in1, {WIDTH{1'b0}}};
          rem_d      = '0;
          quot_d     = '0;
          cnt_d      = '0;
          zero_div_d = (in2 == '0);
          state_d    = RUN;
        end
      end
      RUN: begin
        if (zero_div_q) begin
          // Divide by zero bypasses the iterations entirely.
          state_d = DONE;
          q_out_d  = '1;
          r_out_d  = '0;
          sticky_d = 1'b0;
          dbz_d    = 1'b1;
        end else begin
          rem_d      = step_rem;
          quot_d     = {quot_q[2*WIDTH-2:0], step_q};
          dividend_d = dividend_q << 1;
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_d  = DONE;
            q_out_d  = {quot_q[2*WIDTH-2:0], step_q};
            r_out_d  = step_rem;
            sticky_d = |step_rem;
            dbz_d    = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      zero_div_q <= 1'b0;
      q_out_q    <= '0;
      r_out_q    <= '0;
      sticky_q   <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      divisor_q  <= divisor_d;
      dividend_q <= dividend_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      zero_div_q <= zero_div_d;
      q_out_q    <= q_out_d;
      r_out_q    <= r_out_d;
      sticky_q   <= sticky_d;
      dbz_q      <= dbz_d;
    end
  end

  // Status and result outputs decoded from registered state.
  always_comb begin
    busy   = (state_q == RUN);
    done   = (state_q == DONE);
    Q      = q_out_q;
    R      = r_out_q;
    sticky = sticky_q;
    dbz    = dbz_q;
  end

endmodule

// File: tb/tb_div24_restoring.sv
// Directed-vector bench for div24_restoring with hand-computed results.
module tb_div24_restoring;

  localparam int LIMIT = 200;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [23:0] in1;
  logic [23:0] in2;
  logic        busy;
  logic        done;
  logic [47:0] Q;
  logic [23:0] R;
  logic        sticky;
  logic        dbz;

  int          n_vec;
  int          n_err;
  logic [47:0] prev_q;

  div24_restoring #(
    .WIDTH(24)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .in1    (in1),
    .in2    (in2),
    .busy   (busy),
    .done   (done),
    .Q      (Q),
    .R      (R),
    .sticky (sticky),
    .dbz    (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Issue one operation and follow it to its done pulse; edge 1 is the sampling edge.
  task automatic run_op(input string name, input logic [23:0] a, input logic [23:0] b,
                        input int exp_lat, input logic [47:0] eq, input logic [23:0] er,
                        input logic es, input logic ed, input bit repulse);
    int edges;
    bit seen;
    @(negedge clk);
    in1   = a;
    in2   = b;
    start = 1'b1;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < LIMIT) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) begin
        start = 1'b0;
        in1   = ~a;
        in2   = b ^ 24'h5A5A5A;
      end else if (repulse && (edges == 5 || edges == 20)) begin
        start = 1'b1;
        in1   = 24'h400000;
        in2   = 24'h000003;
      end else if (repulse && (edges == 6 || edges == 21)) begin
        start = 1'b0;
      end
      if (edges == 10) check({name, "/hold_q"}, 64'(Q), 64'(prev_q));
      if (done) seen = 1'b1;
    end
    check({name, "/latency"}, 64'(edges), 64'(exp_lat));
    check({name, "/busy_in_done"}, 64'(busy), 64'(0));
    check({name, "/Q"}, 64'(Q), 64'(eq));
    check({name, "/R"}, 64'(R), 64'(er));
    check({name, "/sticky"}, 64'(sticky), 64'(es));
    check({name, "/dbz"}, 64'(dbz), 64'(ed));
    @(posedge clk);
    #1;
    check({name, "/done_one_cycle"}, 64'(done), 64'(0));
    check({name, "/idle_after"}, 64'(busy), 64'(0));
    prev_q = eq;
  endtask

  initial begin
    int pulses;
    n_vec  = 0;
    n_err  = 0;
    prev_q = '0;
    rst_n  = 1'b0;
    start  = 1'b0;
    in1    = '0;
    in2    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/busy", 64'(busy), 64'(0));
    check("reset/done", 64'(done), 64'(0));
    check("reset/Q", 64'(Q), 64'(0));
    check("reset/R", 64'(R), 64'(0));
    check("reset/sticky", 64'(sticky), 64'(0));
    check("reset/dbz", 64'(dbz), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_op("one_by_one", 24'h800000, 24'h800000, 49, 48'h000001000000, 24'h0, 1'b0, 1'b0, 1'b0);
    run_op("1p5_by_one", 24'hC00000, 24'h800000, 49, 48'h000001800000, 24'h0, 1'b0, 1'b0, 1'b0);
    run_op("one_by_1p5", 24'h800000, 24'hC00000, 49, 48'h000000AAAAAA, 24'h800000, 1'b1, 1'b0,
           1'b0);
    run_op("max_by_1", 24'hFFFFFF, 24'h000001, 49, 48'hFFFFFF000000, 24'h0, 1'b0, 1'b0, 1'b0);
    run_op("div_zero", 24'h123456, 24'h000000, 2, 48'hFFFFFFFFFFFF, 24'h0, 1'b0, 1'b1, 1'b0);
    run_op("zero_num", 24'h000000, 24'h800000, 49, 48'h000000000000, 24'h0, 1'b0, 1'b0, 1'b0);
    run_op("repulse", 24'h800000, 24'hC00000, 49, 48'h000000AAAAAA, 24'h800000, 1'b1, 1'b0,
           1'b1);

    // Abort an operation with reset around iteration 10.
    @(negedge clk);
    in1   = 24'h800000;
    in2   = 24'hC00000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort/busy", 64'(busy), 64'(0));
    check("abort/done", 64'(done), 64'(0));
    check("abort/Q", 64'(Q), 64'(0));
    check("abort/R", 64'(R), 64'(0));
    check("abort/sticky", 64'(sticky), 64'(0));
    check("abort/dbz", 64'(dbz), 64'(0));
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("abort/no_done", 64'(pulses), 64'(0));
    prev_q = '0;
    run_op("after_abort", 24'hC00000, 24'h800000, 49, 48'h000001800000, 24'h0, 1'b0, 1'b0,
           1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
